// File: rtl/desort4_if.sv
// desort4_if: handshake bundle for the four-word de-sort stage.
//   in_valid/in_ready/in_data/in_sel : sorted-word input stream with slot tag
//   out_valid/out_ready              : restored-vector handshake
//   a, b, c, d                       : restored words (slot 0..3)
//   err                              : frame error flag, qualified by out_valid
// Modports: master = upstream/downstream environment, slave = desort4.
interface desort4_if #(parameter int W = 16);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [W-1:0] d;
  logic         err;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, a, b, c, d, err
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, a, b, c, d, err
  );
endinterface

// File: rtl/desort4.sv
// desort4: four-word de-sort (scatter) stage.
// Collects four words, each tagged with its original slot code, writes each
// back to slot a/b/c/d, then presents the restored vector with valid/ready.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : desort4_if.slave (input stream, output vector, err)
// Optional feature: define DESORT4_ORDER_CHECK_EN to also flag any word that
// is larger (unsigned) than the previous word of the same frame.
module desort4 #(
  parameter int W = 16
) (
  input  logic      clk,
  input  logic      rst,
  desort4_if.slave  bus
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  logic [0:0]   state;
  logic [W-1:0] slot [4];
  logic [3:0]   filled;
  logic [1:0]   count;
  logic         err_q;
  logic         accept;
  logic         dup;
  logic         order_bad;
  logic         release_frame;

`ifdef DESORT4_ORDER_CHECK_EN
  logic [W-1:0] prev;
  // The first word of a frame has no predecessor, so it is never out of order.
  assign order_bad = (count != 2'd0) && (bus.in_data > prev);
`else
  assign order_bad = 1'b0;
`endif

  // Ready is a pure decode of the state register (gated by reset) so there is
  // no combinational path from in_valid or out_ready.
  assign bus.in_ready   = ~rst & (state == COLLECT);
  assign bus.out_valid  = (state == HOLD);
  assign accept         = bus.in_valid & bus.in_ready;
  assign dup            = filled[bus.in_sel];
  assign release_frame  = (state == HOLD) & bus.out_ready;

  assign bus.a   = slot[0];
  assign bus.b   = slot[1];
  assign bus.c   = slot[2];
  assign bus.d   = slot[3];
  assign bus.err = err_q;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= COLLECT;
      filled <= 4'd0;
      count  <= 2'd0;
      err_q  <= 1'b0;
      // NOTE: the slot array is reset explicitly because a slot never written
      // in a frame must read as zero; it is too small to need a RAM.
      for (int i = 0; i < 4; i++) slot[i] <= '0;
`ifdef DESORT4_ORDER_CHECK_EN
      prev   <= '0;
`endif
    end else if (accept) begin
      slot[bus.in_sel]   <= bus.in_data;
      filled[bus.in_sel] <= 1'b1;
      count              <= count + 2'd1;   // wraps to 0 on the 4th accept
      if (dup || order_bad) err_q <= 1'b1;
`ifdef DESORT4_ORDER_CHECK_EN
      prev               <= bus.in_data;
`endif
      if (count == 2'd3) state <= HOLD;
    end else if (release_frame) begin
      state  <= COLLECT;
      filled <= 4'd0;
      err_q  <= 1'b0;
      for (int i = 0; i < 4; i++) slot[i] <= '0;
    end
  end

endmodule

// File: tb/tb_desort4.sv
// tb_desort4: self-checking bench for desort4. Expected vectors come from a
// frame-level model: replay the four (data, slot) pairs into a zeroed array,
// flag any repeated slot, and (when the order check is built in) any word
// larger than its predecessor.
module tb_desort4;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   sel;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  desort4_if #(.W(W)) bus ();
  desort4 #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;

  word_t        frame [4];
  logic [W-1:0] exp_slot [4];
  logic         exp_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int k, input logic [W-1:0] data, input logic [1:0] sel);
    frame[k].data = data;
    frame[k].sel  = sel;
  endtask

  // Reference model: what the restored vector and error flag must be.
  task automatic model();
    bit seen [4];
    for (int i = 0; i < 4; i++) begin
      exp_slot[i] = '0;
      seen[i]     = 1'b0;
    end
    exp_err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (seen[frame[k].sel]) exp_err = 1'b1;
      seen[frame[k].sel]     = 1'b1;
      exp_slot[frame[k].sel] = frame[k].data;
`ifdef DESORT4_ORDER_CHECK_EN
      if (k > 0 && frame[k].data > frame[k-1].data) exp_err = 1'b1;
`endif
    end
  endtask

  function automatic logic [4*W:0] exp_vec();
    return {exp_slot[0], exp_slot[1], exp_slot[2], exp_slot[3], exp_err};
  endfunction

  function automatic logic [4*W:0] got_vec();
    return {bus.a, bus.b, bus.c, bus.d, bus.err};
  endfunction

  // Presents the four words of frame[] on consecutive cycles.
  task automatic drive_frame();
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = frame[k].data;
      bus.in_sel   = frame[k].sel;
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'hBEEF;
    bus.in_sel    = 2'd1;
    bus.out_ready = 1'b0;
    step();
    step();
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    vectors++;
    if ({bus.out_valid, got_vec()} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b vec=%h expected all 0", bus.out_valid, got_vec());
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    set_word(0, 16'h9000, 2'd2);
    set_word(1, 16'h7000, 2'd0);
    set_word(2, 16'h4000, 2'd3);
    set_word(3, 16'h1000, 2'd1);
    bus.out_ready = 1'b1;
    drive_frame();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_valid: got valid=%b ready=%b expected 1/0", bus.out_valid, bus.in_ready);
    end
    vectors++;
    if (got_vec() !== {16'h7000, 16'h1000, 16'h9000, 16'h4000, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_vector: got %h expected %h", got_vec(),
               {16'h7000, 16'h1000, 16'h9000, 16'h4000, 1'b0});
    end
    step();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || got_vec() !== '0) begin
      miscompares++;
      $display("FAIL basic_release: got valid=%b ready=%b vec=%h expected 0/1/0",
               bus.out_valid, bus.in_ready, got_vec());
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    set_word(0, 16'h9000, 2'd2);
    set_word(1, 16'h7000, 2'd0);
    set_word(2, 16'h4000, 2'd3);
    set_word(3, 16'h1000, 2'd1);
    model();
    bus.out_ready = 1'b0;
    drive_frame();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL hold_stable[%0d]: got ready=%b valid=%b vec=%h expected 0/1/%h",
                 i, bus.in_ready, bus.out_valid, got_vec(), exp_vec());
      end
      bus.in_valid = 1'b1;
      bus.in_data  = W'($urandom);
      bus.in_sel   = 2'($urandom);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || got_vec() !== '0) begin
      miscompares++;
      $display("FAIL hold_release: got valid=%b ready=%b vec=%h expected 0/1/0",
               bus.out_valid, bus.in_ready, got_vec());
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_duplicate();
    set_word(0, 16'h8000, 2'd1);
    set_word(1, 16'h6000, 2'd1);
    set_word(2, 16'h5000, 2'd0);
    set_word(3, 16'h2000, 2'd3);
    drive_frame();
    vectors++;
    if (bus.out_valid !== 1'b1 ||
        got_vec() !== {16'h5000, 16'h6000, 16'h0000, 16'h2000, 1'b1}) begin
      miscompares++;
      $display("FAIL duplicate_frame: got valid=%b vec=%h expected 1/%h", bus.out_valid,
               got_vec(), {16'h5000, 16'h6000, 16'h0000, 16'h2000, 1'b1});
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h9000;
    bus.in_sel   = 2'd2;
    step();
    bus.in_data  = 16'h7000;
    bus.in_sel   = 2'd2;           // duplicate, so err is set before reset
    step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || got_vec() !== '0) begin
      miscompares++;
      $display("FAIL midreset_clear: got valid=%b ready=%b vec=%h expected 0/0/0",
               bus.out_valid, bus.in_ready, got_vec());
    end
    rst = 1'b0;
    set_word(0, 16'h9000, 2'd2);
    set_word(1, 16'h7000, 2'd0);
    set_word(2, 16'h4000, 2'd3);
    set_word(3, 16'h1000, 2'd1);
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = frame[k].data;
      bus.in_sel   = frame[k].sel;
      step();
    end
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_count: got out_valid=%b after 3 words expected 0", bus.out_valid);
    end
    bus.in_data = frame[3].data;
    bus.in_sel  = frame[3].sel;
    step();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 ||
        got_vec() !== {16'h7000, 16'h1000, 16'h9000, 16'h4000, 1'b0}) begin
      miscompares++;
      $display("FAIL midreset_refill: got valid=%b vec=%h expected 1/%h", bus.out_valid,
               got_vec(), {16'h7000, 16'h1000, 16'h9000, 16'h4000, 1'b0});
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_order();
    logic exp_order_err;
`ifdef DESORT4_ORDER_CHECK_EN
    exp_order_err = 1'b1;
`else
    exp_order_err = 1'b0;
`endif
    set_word(0, 16'h3000, 2'd0);
    set_word(1, 16'h5000, 2'd1);
    set_word(2, 16'h2000, 2'd2);
    set_word(3, 16'h2000, 2'd3);
    drive_frame();
    vectors++;
    if (bus.out_valid !== 1'b1 ||
        got_vec() !== {16'h3000, 16'h5000, 16'h2000, 16'h2000, exp_order_err}) begin
      miscompares++;
      $display("FAIL order_frame: got valid=%b vec=%h expected 1/%h", bus.out_valid,
               got_vec(), {16'h3000, 16'h5000, 16'h2000, 16'h2000, exp_order_err});
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  // Cycle numbering: cycle 1 is the one ending at the first edge of the
  // window, so out_valid seen after edges 4 and 9 is cycles 5 and 10.
  task automatic test_back_to_back();
    word_t words [8];
    int    idx    = 0;
    int    pulses = 0;
    logic  acc;
    for (int f = 0; f < 2; f++) begin
      int perm [4];
      for (int i = 0; i < 4; i++) perm[i] = i;
      for (int i = 3; i > 0; i--) begin
        int j = int'($urandom_range(i));
        int t = perm[i];
        perm[i] = perm[j];
        perm[j] = t;
      end
      for (int i = 0; i < 4; i++) begin
        words[4*f+i].sel  = 2'(perm[i]);
        words[4*f+i].data = W'(16'hF000 - 16'(i * 16'h1000) - 16'(f * 16'h0100));
      end
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = words[0].data;
    bus.in_sel    = words[0].sel;
    for (int e = 1; e <= 10; e++) begin
      acc = bus.in_valid & bus.in_ready;
      step();
      if (acc) idx++;
      vectors++;
      if (bus.out_valid !== (e == 4 || e == 9)) begin
        miscompares++;
        $display("FAIL b2b_valid[cycle %0d]: got %b expected %b", e + 1, bus.out_valid,
                 (e == 4 || e == 9));
      end
      if (bus.out_valid === 1'b1 && idx >= 4) begin
        pulses++;
        for (int k = 0; k < 4; k++) frame[k] = words[idx-4+k];
        model();
        vectors++;
        if (got_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL b2b_vector[cycle %0d]: got %h expected %h", e + 1, got_vec(), exp_vec());
        end
      end
      if (idx < 8) begin
        bus.in_data = words[idx].data;
        bus.in_sel  = words[idx].sel;
      end else begin
        bus.in_data = W'($urandom);
        bus.in_sel  = 2'($urandom);
      end
    end
    vectors++;
    if (idx !== 8 || pulses !== 2) begin
      miscompares++;
      $display("FAIL b2b_counts: got accepts=%0d frames=%0d expected 8/2", idx, pulses);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int   k      = 0;
      int   budget = 0;
      int   stall;
      logic acc;
      logic [W-1:0] vals [4];
      for (int i = 0; i < 4; i++) vals[i] = W'($urandom);
      if ($urandom_range(1) == 1) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3 - i; j++)
            if (vals[j] < vals[j+1]) begin
              logic [W-1:0] t = vals[j];
              vals[j]   = vals[j+1];
              vals[j+1] = t;
            end
      end
      for (int i = 0; i < 4; i++) set_word(i, vals[i], 2'($urandom));
      model();
      while (k < 4 && budget < 50) begin
        if ($urandom_range(3) == 0) begin
          bus.in_valid = 1'b0;
          bus.in_data  = W'($urandom);
          bus.in_sel   = 2'($urandom);
        end else begin
          bus.in_valid = 1'b1;
          bus.in_data  = frame[k].data;
          bus.in_sel   = frame[k].sel;
        end
        acc = bus.in_valid & bus.in_ready;
        step();
        budget++;
        if (acc) k++;
        if (k < 4) begin
          vectors++;
          if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_early_valid[%0d]: got 1 after %0d words expected 0", n, k);
          end
        end
      end
      vectors++;
      if (k < 4) begin
        miscompares++;
        $display("FAIL rand_accept_timeout[%0d]: got %0d words expected 4", n, k);
      end
      stall = int'($urandom_range(3));
      for (int s = 0; s <= stall; s++) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || got_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL rand_hold[%0d.%0d]: got valid=%b vec=%h expected 1/%h",
                   n, s, bus.out_valid, got_vec(), exp_vec());
        end
        bus.in_valid  = 1'($urandom);
        bus.in_data   = W'($urandom);
        bus.in_sel    = 2'($urandom);
        bus.out_ready = (s == stall);
        step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || got_vec() !== '0) begin
        miscompares++;
        $display("FAIL rand_release[%0d]: got valid=%b ready=%b vec=%h expected 0/1/0",
                 n, bus.out_valid, bus.in_ready, got_vec());
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = 2'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_hold_stall();
    test_duplicate();
    test_mid_reset();
    test_order();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/desort4.md
# desort4

Four-word de-sort (scatter) stage: the inverse of the greatest-of-four selector and sorter path. It accepts a stream of words in descending order, each tagged with the 2-bit slot code (`sel`) produced by the selector's encoder. It writes each word back into its original slot position `a`, `b`, `c` or `d`. Once four words are collected, it presents the restored vector with a valid/ready handshake. It sits downstream of the sorter, or at the far end of a link that carries sorted words plus their origin indices.

## Interface
- `W`, default 16: data word width.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: an input word is offered.
- `in_ready`, output, 1: block can accept a word.
- `in_data`, input, W: sorted word.
- `in_sel`, input, 2: original slot of `in_data`, where 0=`a`, 1=`b`, 2=`c`, 3=`d` (same code as the selector's `selout`).
- `out_valid`, output, 1: restored vector is available.
- `out_ready`, input, 1: downstream accepts the vector.
- `a`, `b`, `c`, `d`, output, W each: restored words.
- `err`, output, 1: frame error flag. It is qualified by `out_valid`.

## Operation
- Two states:
  - COLLECT (reset state): `in_ready`=1.
  - HOLD: `out_valid`=1, `in_ready`=0.
- Input accept occurs when `in_valid & in_ready`:
  - slot `in_sel` ← `in_data`;
  - the slot's bit in the 4-bit `filled` mask is set;
  - the 2-bit count increments.
- An accept at count=3 completes the frame. Next state is HOLD and the count wraps to 0.
- Duplicate slot: an accept whose `in_sel` bit is already set in `filled` sets `err`.
  - The slot is overwritten with the new word.
  - The count still increments, so the frame still closes after 4 accepts.
  - Any never-written slot reads 0.
- Output handshake occurs when `out_valid & out_ready` in HOLD. Then, in the same edge:
  - next state is COLLECT;
  - `a`..`d` are cleared to 0;
  - `filled` is cleared to 0;
  - `err` is cleared to 0.
- `a`..`d` and `err` are stable throughout HOLD, regardless of `in_*` activity.
- Inputs offered during HOLD are not accepted (`in_ready`=0) and have no effect.
- Reset mid-frame: the partial frame is discarded. All state and outputs return to reset values on the next edge.

## Timing
- Reset values: state=COLLECT, `out_valid`=0, `a`=`b`=`c`=`d`=0, `err`=0, count=0, `filled`=0.
- `in_ready` is 0 while `rst` is high. Otherwise `in_ready` is decoded from the state register, with no combinational path from `in_valid` or `out_ready`.
- Throughput: one word per cycle during COLLECT.
- Latency: `out_valid` rises on the edge that accepts the 4th word. `a`..`d` are valid in that same cycle.
- Best-case frame period: 5 cycles (4 accepts + 1 HOLD cycle with `out_ready`=1).
- When HOLD exits, `in_ready` returns to 1 in the following cycle. There is no same-cycle out/in overlap.
- `out_valid` never drops without a handshake, except on reset.

## Configuration
- `DESORT4_ORDER_CHECK_EN` defined:
  - the block keeps a W-bit register holding the previous accepted word of the frame;
  - any accept with count≠0 and `in_data` > previous word (unsigned) sets `err`;
  - equal words are legal.
- Macro undefined: the order check and its register are absent, and `err` reports duplicate slots only.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then 4 accepts of (0x9000,sel2), (0x7000,sel0), (0x4000,sel3), (0x1000,sel1), with `out_ready`=1:
  - `out_valid`=1 in the cycle after the 4th accept;
  - outputs a=0x7000, b=0x1000, c=0x9000, d=0x4000, `err`=0;
  - `in_ready`=1 again one cycle later.
- Same frame with `out_ready`=0 for 5 cycles while `in_valid`=1 with changing data:
  - `in_ready`=0 throughout;
  - outputs hold their values;
  - the handshake on cycle 6 returns to COLLECT with a..d=0.
- Duplicate frame (0x8000,sel1), (0x6000,sel1), (0x5000,sel0), (0x2000,sel3):
  - `err`=1, a=0x5000, b=0x6000, c=0, d=0x2000.
- Reset asserted after 2 accepts:
  - after the edge, `out_valid`=0, a..d=0, `err`=0;
  - a fresh full 4-word frame then restores correctly.
- With `DESORT4_ORDER_CHECK_EN`, the frame (0x3000,sel0), (0x5000,sel1), (0x2000,sel2), (0x2000,sel3) gives `err`=1.
  - Without the macro, the same frame gives `err`=0, with a=0x3000, b=0x5000, c=0x2000, d=0x2000.
- Back-to-back frames with `in_valid` and `out_ready` held high for 10 cycles:
  - exactly 2 frames complete;
  - `out_valid` pulses in cycles 5 and 10;
  - no word is lost or duplicated.
